// File: rtl/router_b_sequencer.sv
// rtl/router_b_sequencer.sv - micro-op sequencer driving bank addresses, router_b selects and ALU control.
// Optional multi-pass repeat enabled by defining SEQ_REPEAT_EN.
module router_b_sequencer #(
  parameter int AW = 5,
  parameter int PW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_we,
  input  logic [PW-1:0]        prog_addr,
  input  logic [3*AW+17:0]     prog_wdata,
  input  logic                 start,
  input  logic [PW-1:0]        start_pc,
  input  logic                 abort,
  input  logic                 alu_done,
  input  logic [3:0]           rep_count,
  output logic [AW-1:0]        addr_A,
  output logic [AW-1:0]        addr_B,
  output logic [1:0]           sel_R,
  output logic [1:0]           sel_S,
  output logic                 inv_R,
  output logic                 inv_S,
  output logic [1:0]           sel_I,
  output logic [3:0]           alu_op,
  output logic                 alu_go,
  output logic                 ld_RQ,
  output logic                 ld_RD,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic                 busy,
  output logic                 done
);

  localparam int UW = 3*AW + 18;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_OPER, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pc, pc_nx;
  logic [UW-1:0]   uop;
  logic [UW-1:0]   mem [2**PW];
  logic            rerun;
  logic            seq_unused;

  // Field map, LSB upward; bit UW-1 is a reserved spare.
  logic            u_last, u_wait, u_ld_rd, u_ld_rq, u_wr_en, u_inv_s, u_inv_r;
  logic [AW-1:0]   u_wr_addr, u_addr_b, u_addr_a;
  logic [3:0]      u_alu_op;
  logic [1:0]      u_sel_i, u_sel_s, u_sel_r;

  assign u_last    = uop[0];
  assign u_wait    = uop[1];
  assign u_ld_rd   = uop[2];
  assign u_ld_rq   = uop[3];
  assign u_wr_en   = uop[4];
  assign u_wr_addr = uop[AW+4:5];
  assign u_addr_b  = uop[2*AW+4:AW+5];
  assign u_addr_a  = uop[3*AW+4:2*AW+5];
  assign u_alu_op  = uop[3*AW+8:3*AW+5];
  assign u_sel_i   = uop[3*AW+10:3*AW+9];
  assign u_inv_s   = uop[3*AW+11];
  assign u_inv_r   = uop[3*AW+12];
  assign u_sel_s   = uop[3*AW+14:3*AW+13];
  assign u_sel_r   = uop[3*AW+16:3*AW+15];

`ifdef SEQ_REPEAT_EN
  logic [3:0]      pass_cnt;
  logic [PW-1:0]   start_pc_q;

  assign rerun      = (pass_cnt != 4'd0);
  assign seq_unused = uop[UW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt   <= 4'd0;
      start_pc_q <= '0;
    end else if (state == S_IDLE && start) begin
      pass_cnt   <= rep_count;
      start_pc_q <= start_pc;
    end else if (state == S_WB && !abort && u_last && rerun) begin
      pass_cnt   <= pass_cnt - 4'd1;
    end
  end
`else
  assign rerun      = 1'b0;
  assign seq_unused = ^{uop[UW-1], rep_count};
`endif

  // Program store is deliberately not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE)
      mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      uop   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == S_FETCH)
        uop <= mem[pc];
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    case (state)
      S_IDLE:  if (start) begin
                 pc_nx    = start_pc;
                 state_nx = S_FETCH;
               end
      S_FETCH: state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_OPER;
      S_OPER:  state_nx = u_wait ? S_WAIT : S_WB;
      S_WAIT:  if (alu_done) state_nx = S_WB;
      S_WB: begin
        if (u_last) begin
          if (rerun) begin
`ifdef SEQ_REPEAT_EN
            pc_nx    = start_pc_q;
`endif
            state_nx = S_FETCH;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          pc_nx    = pc + PW'(1);
          state_nx = S_FETCH;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE)
      state_nx = S_IDLE;
  end

  logic drive;
  assign drive = (state == S_ISSUE) || (state == S_OPER) ||
                 (state == S_WAIT)  || (state == S_WB);

  // Addresses follow the uop register, which only changes in FETCH, so they hold.
  assign addr_A  = u_addr_a;
  assign addr_B  = u_addr_b;
  assign wr_addr = u_wr_addr;
  assign sel_R   = drive ? u_sel_r  : 2'd0;
  assign sel_S   = drive ? u_sel_s  : 2'd0;
  assign inv_R   = drive & u_inv_r;
  assign inv_S   = drive & u_inv_s;
  assign sel_I   = drive ? u_sel_i  : 2'd0;
  assign alu_op  = drive ? u_alu_op : 4'd0;
  assign alu_go  = (state == S_OPER);
  assign wr_en   = (state == S_WB) & u_wr_en;
  assign ld_RQ   = (state == S_WB) & u_ld_rq;
  assign ld_RD   = (state == S_WB) & u_ld_rd;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_router_b_sequencer.sv
// tb/tb_router_b_sequencer.sv - scoreboard bench for router_b_sequencer.
module tb_router_b_sequencer;

  localparam int AW = 5;
  localparam int PW = 4;
  localparam int UW = 3*AW + 18;

  typedef struct packed {
    logic [1:0] sel_r, sel_s;
    logic       inv_r, inv_s;
    logic [1:0] sel_i;
    logic [3:0] alu_op;
    logic [4:0] a, b, w;
    logic       wen, lq, ld, wt, last;
  } op_t;

  typedef struct {
    int          rel;
    logic [63:0] data;
  } drv_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [UW-1:0] prog_wdata = '0;
  logic          start = 1'b0;
  logic [PW-1:0] start_pc = '0;
  logic          abort = 1'b0;
  logic          alu_done = 1'b0;
  logic [3:0]    rep_count = '0;
  logic [AW-1:0] addr_A, addr_B, wr_addr;
  logic [1:0]    sel_R, sel_S, sel_I;
  logic          inv_R, inv_S, alu_go, ld_RQ, ld_RD, wr_en, busy, done;
  logic [3:0]    alu_op;

  router_b_sequencer #(.AW(AW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .start_pc(start_pc),
    .abort(abort), .alu_done(alu_done), .rep_count(rep_count),
    .addr_A(addr_A), .addr_B(addr_B), .sel_R(sel_R), .sel_S(sel_S),
    .inv_R(inv_R), .inv_S(inv_S), .sel_I(sel_I), .alu_op(alu_op),
    .alu_go(alu_go), .ld_RQ(ld_RQ), .ld_RD(ld_RD), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  bit active = 0;
  int n_chk = 0;
  int n_fail = 0;
  op_t img [16];
  logic [63:0] exp_q [$];
  drv_t dq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input int kind, input int rel, input logic [47:0] d);
    return {4'(kind), 12'(rel), d};
  endfunction

  function automatic logic [47:0] go_data(input op_t o);
    return {26'd0, o.sel_r, o.sel_s, o.inv_r, o.inv_s, o.sel_i, o.alu_op, o.a, o.b};
  endfunction

  function automatic logic [47:0] wb_data(input op_t o);
    return {28'd0, o.wen, o.lq, o.ld, o.w, o.sel_r, o.sel_s, o.inv_r, o.inv_s, o.sel_i, o.alu_op};
  endfunction

  function automatic logic [47:0] obs_go();
    return {26'd0, sel_R, sel_S, inv_R, inv_S, sel_I, alu_op, addr_A, addr_B};
  endfunction

  function automatic logic [47:0] obs_wb();
    return {28'd0, wr_en, ld_RQ, ld_RD, wr_addr, sel_R, sel_S, inv_R, inv_S, sel_I, alu_op};
  endfunction

  function automatic logic [63:0] all_outs();
    return {31'd0, addr_A, addr_B, sel_R, sel_S, inv_R, inv_S, sel_I, alu_op,
            alu_go, ld_RQ, ld_RD, wr_en, wr_addr, busy, done};
  endfunction

  task automatic cmp_ev(input string tag, input logic [63:0] e);
    if (exp_q.size() == 0) check({tag, "_unexpected"}, e, 64'd0);
    else check(tag, e, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (alu_go) cmp_ev("go", ev(1, cyc - base, obs_go()));
      if (wr_en | ld_RQ | ld_RD) cmp_ev("wb", ev(2, cyc - base, obs_wb()));
      if (done) cmp_ev("done", ev(3, cyc - base, 48'd0));
    end
  end

  // Reference timeline: FETCH, ISSUE, OPER (+WAIT), WB per op, then DONE.
  task automatic plan(input int spc, input int passes, input int dly, output int t_end);
    int t = 0;
    for (int p = 0; p < passes; p++) begin
      int  pc = spc;
      bit  fin = 0;
      for (int k = 0; k < 16 && !fin; k++) begin
        op_t o = img[pc];
        t += 3;
        exp_q.push_back(ev(1, t, go_data(o)));
        if (o.wt) begin
          dq.push_back('{t + dly, {16'd0, go_data(o)}});
          t += dly + 1;
        end else begin
          t += 1;
        end
        if (o.wen | o.lq | o.ld) exp_q.push_back(ev(2, t, wb_data(o)));
        if (o.last) fin = 1;
        pc = (pc + 1) % 16;
      end
    end
    t += 1;
    exp_q.push_back(ev(3, t, 48'd0));
    t_end = t;
  endtask

  task automatic run(input int spc, input int rep, input int budget,
                     input int abort_rel, input int we_rel);
    @(negedge clk);
    start = 1'b1; start_pc = PW'(spc); rep_count = 4'(rep);
    base = cyc; active = 1;
    for (int i = 1; i <= budget; i++) begin
      int rel;
      @(negedge clk);
      start = 1'b0;
      rel = cyc - base;
      alu_done = 1'b0;
      if (dq.size() > 0 && dq[0].rel == rel) begin
        alu_done = 1'b1;
        check("wait_hold", {16'd0, obs_go()}, dq[0].data);
        void'(dq.pop_front());
      end
      abort = (rel == abort_rel);
      prog_we = (rel == we_rel);
      prog_addr = 4'd2;
      prog_wdata = '1;
      if (abort_rel > 0 && rel == abort_rel + 1) check("abort_busy", 64'(busy), 64'd0);
    end
    alu_done = 1'b0; abort = 1'b0; prog_we = 1'b0;
    check("drain", 64'(exp_q.size()), 64'd0);
    active = 0;
    exp_q.delete();
    dq.delete();
  endtask

  initial begin
    int te;
    #1;
    check("reset_outs", all_outs(), 64'd0);
    img[2]  = '{2'd1, 2'd2, 1'b1, 1'b0, 2'd3, 4'h5, 5'd3,  5'd4,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    img[3]  = '{2'd2, 2'd1, 1'b0, 1'b1, 2'd1, 4'hA, 5'd9,  5'd10, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    img[4]  = '{2'd3, 2'd3, 1'b1, 1'b1, 2'd2, 4'h3, 5'd20, 5'd21, 5'd22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    img[6]  = '{2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 4'h7, 5'd1,  5'd2,  5'd30, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    img[8]  = '{2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 4'h2, 5'd5,  5'd6,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    img[15] = '{2'd2, 2'd0, 1'b1, 1'b0, 2'd0, 4'h9, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    img[0]  = '{2'd0, 2'd2, 1'b0, 1'b1, 2'd2, 4'hC, 5'd15, 5'd16, 5'd17, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (img[a]) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = PW'(a); prog_wdata = {1'b0, img[a]};
    end
    @(negedge clk);
    prog_we = 1'b0;

    plan(2, 1, 0, te);            // three ops: go 3,7,11; done 13
    run(2, 0, te + 3, 0, 0);
    plan(6, 1, 5, te);            // wait op, alu_done 5 cycles after go
    run(6, 0, te + 3, 0, 0);
    plan(15, 1, 0, te);           // pc wraps 15 -> 0; done at 9
    run(15, 0, te + 3, 0, 0);

    exp_q.push_back(ev(1, 3, go_data(img[6])));
    dq.push_back('{6, {16'd0, go_data(img[6])}});
    run(6, 0, 12, 6, 0);          // abort together with alu_done in WAIT

`ifdef SEQ_REPEAT_EN
    plan(8, 3, 0, te);
`else
    plan(8, 1, 0, te);
`endif
    run(8, 2, te + 3, 0, 2);      // also tries to overwrite mem[2] while busy
    plan(2, 1, 0, te);
    run(2, 0, te + 3, 0, 0);

    @(negedge clk);
    start = 1'b1; start_pc = 4'd2; rep_count = 4'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("midrun_reset_outs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("post_reset_idle", {62'd0, busy, done}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
